ace_rr_arbiter: RTL and testbench

//   Parametrised N-master arbiter for the ACE interconnect request path.

---
 rtl/ace_rr_arbiter.sv | 101 ++++++++++
 tb/tb_ace_rr_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ace_rr_arbiter.sv
// rtl/ace_rr_arbiter.sv - N-master request arbiter with held grant, round-robin or fixed priority
module ace_rr_arbiter #(
    parameter int NUM_MASTERS = 8,
    parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    parameter bit RR_MODE     = 1'b1
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   txn_done,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   grant_valid
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // One extra bit so base+offset can be folded back below NUM_MASTERS
    localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_MASTERS);

    logic [0:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;

    logic [IDX_W-1:0]       scan_base;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W:0]         cand;
    logic [IDX_W:0]         win_plus1;
    logic [IDX_W-1:0]       ptr_wrap;

    // Fixed priority is simply a scan that always starts at index 0
    assign scan_base = RR_MODE ? ptr_q : '0;

    // Scan base, base+1, ... modulo NUM_MASTERS; walking downward lets the nearest requester win
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            cand = {1'b0, scan_base} + (IDX_W+1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Pointer moves just past the winner, wrapping at NUM_MASTERS rather than 2**IDX_W
    always_comb begin
        win_plus1 = {1'b0, win_idx} + (IDX_W+1)'(1);
        ptr_wrap  = (win_plus1 >= N_EXT) ? '0 : win_plus1[IDX_W-1:0];
    end

    // Arbitrate when idle or when the held transaction finishes; otherwise freeze everything
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if ((state_q == ST_IDLE) || txn_done) begin
            if (win_found) begin
                state_d = ST_BUSY;
                idx_d   = win_idx;
                grant_d = NUM_MASTERS'(1) << win_idx;
                if (RR_MODE) begin
                    ptr_d = ptr_wrap;
                end
            end else begin
                state_d = ST_IDLE;
                idx_d   = '0;
                grant_d = '0;
            end
        end
    end

    // State and output registers; reset drops the grant immediately
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = (state_q == ST_BUSY);

endmodule

// File: tb/tb_ace_rr_arbiter.sv
// tb/tb_ace_rr_arbiter.sv - self-checking bench for ace_rr_arbiter (8 RR, 8 fixed, 5 RR)
module tb_ace_rr_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] req8;
    logic [4:0] req5;
    logic       done;

    logic [7:0] g_rr, g_fp;
    logic [2:0] i_rr, i_fp, i5;
    logic [4:0] g5;
    logic       v_rr, v_fp, v5;

    int tests = 0;
    int fails = 0;

    // Reference model: per instance busy flag, granted index, rotation pointer
    int nm [3] = '{8, 8, 5};
    bit rr [3] = '{1'b1, 1'b0, 1'b1};
    int m_busy [3];
    int m_idx  [3];
    int m_ptr  [3];

    always #5 clk = ~clk;

    ace_rr_arbiter #(.NUM_MASTERS(8), .RR_MODE(1'b1)) u_rr8 (
        .ACLK(clk), .ARESETn(rstn), .req(req8), .txn_done(done),
        .grant(g_rr), .grant_idx(i_rr), .grant_valid(v_rr));

    ace_rr_arbiter #(.NUM_MASTERS(8), .RR_MODE(1'b0)) u_fp8 (
        .ACLK(clk), .ARESETn(rstn), .req(req8), .txn_done(done),
        .grant(g_fp), .grant_idx(i_fp), .grant_valid(v_fp));

    ace_rr_arbiter #(.NUM_MASTERS(5), .RR_MODE(1'b1)) u_rr5 (
        .ACLK(clk), .ARESETn(rstn), .req(req5), .txn_done(done),
        .grant(g5), .grant_idx(i5), .grant_valid(v5));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 0;
            m_idx[k]  = 0;
            m_ptr[k]  = 0;
        end
    endtask

    // One clock edge of the arbitration rules for instance k
    task automatic model_edge(input int k, input int reqv, input bit txn);
        int w;
        int i;
        if (m_busy[k] == 0 || txn) begin
            w = -1;
            for (int off = 0; off < nm[k]; off++) begin
                i = rr[k] ? (m_ptr[k] + off) % nm[k] : off;
                if (w < 0 && reqv[i]) w = i;
            end
            if (w >= 0) begin
                m_busy[k] = 1;
                m_idx[k]  = w;
                if (rr[k]) m_ptr[k] = (w + 1) % nm[k];
            end else begin
                m_busy[k] = 0;
                m_idx[k]  = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_grant(input int k);
        return (m_busy[k] != 0) ? (32'd1 << m_idx[k]) : 32'd0;
    endfunction

    task automatic check_all();
        check("rr8_grant", {24'd0, g_rr}, exp_grant(0));
        check("rr8_idx",   {29'd0, i_rr}, m_idx[0]);
        check("rr8_valid", {31'd0, v_rr}, m_busy[0]);
        check("fp8_grant", {24'd0, g_fp}, exp_grant(1));
        check("fp8_idx",   {29'd0, i_fp}, m_idx[1]);
        check("fp8_valid", {31'd0, v_fp}, m_busy[1]);
        check("rr5_grant", {27'd0, g5},   exp_grant(2));
        check("rr5_idx",   {29'd0, i5},   m_idx[2]);
        check("rr5_valid", {31'd0, v5},   m_busy[2]);
    endtask

    task automatic step();
        @(posedge clk);
        if (rstn) begin
            model_edge(0, int'(req8), done);
            model_edge(1, int'(req8), done);
            model_edge(2, int'(req5), done);
        end
        #1;
        check_all();
        check("rr5_idx_below_n", {31'd0, (i5 < 3'd5)}, 32'd1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        req8 = 8'hFF;
        req5 = 5'b10001;
        done = 1'b0;
        model_reset();
        #2;
        check_all();
        step();
        step();
        check("t1_reset_grant", {24'd0, g_rr}, 32'd0);
        rstn = 1'b1;
        step();
        check("t1_first_idx", {29'd0, i_rr}, 32'd0);
        check("t1_first_valid", {31'd0, v_rr}, 32'd1);

        // Rotation with all masters requesting, txn_done every third cycle
        for (int i = 0; i < 8; i++) begin
            done = 1'b0;
            step();
            step();
            done = 1'b1;
            step();
            check("t2_rr_idx", {29'd0, i_rr}, (i + 1) % 8);
            check("t2_rr_valid", {31'd0, v_rr}, 32'd1);
            check("t2_fp_idx", {29'd0, i_fp}, 32'd0);
            check("t5_n5_idx", {29'd0, i5}, (i % 2 == 0) ? 32'd4 : 32'd0);
        end
        done = 1'b0;

        // Fixed priority keeps picking the lowest index
        req8 = 8'b1010_0100;
        for (int i = 0; i < 3; i++) begin
            step();
            done = 1'b1;
            step();
            done = 1'b0;
            check("t3_fp_idx", {29'd0, i_fp}, 32'd2);
        end
        req8 = 8'b1010_0000;
        done = 1'b1;
        step();
        done = 1'b0;
        check("t3_fp_drop", {29'd0, i_fp}, 32'd5);

        // Grant frozen while busy, then pointer wraps to master 1
        req8 = 8'h08;
        done = 1'b1;
        step();
        done = 1'b0;
        check("t4_rr_idx3", {29'd0, i_rr}, 32'd3);
        for (int j = 0; j < 10; j++) begin
            req8 = (j % 2 == 0) ? 8'h02 : 8'h0A;
            step();
            check("t4_hold", {29'd0, i_rr}, 32'd3);
        end
        req8 = 8'h02;
        done = 1'b1;
        step();
        done = 1'b0;
        check("t4_after_done", {29'd0, i_rr}, 32'd1);

        // Asynchronous reset in the middle of a grant
        req8 = 8'h40;
        done = 1'b1;
        step();
        done = 1'b0;
        check("t6_idx6", {29'd0, i_rr}, 32'd6);
        step();
        do_reset();
        check("t6_async_valid", {31'd0, v_rr}, 32'd0);
        check("t6_async_grant", {24'd0, g_rr}, 32'd0);
        step();
        rstn = 1'b1;
        req8 = 8'hC0;
        step();
        check("t6_restart_rr", {29'd0, i_rr}, 32'd6);
        check("t6_restart_fp", {29'd0, i_fp}, 32'd6);

        // Randomized traffic against the model, with occasional resets
        for (int n = 0; n < 800; n++) begin
            req8 = 8'($urandom);
            req5 = 5'($urandom);
            done = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
                step();
                rstn = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
